// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle RV32I(M) control unit.
package control_pkg;
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
      ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, MULDIV, TRAP
   } state_t;

   typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_R, ALUOP_I} alu_ops_t;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_ctrl_t;
   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_ctrl_t;
   typedef enum logic       {MADR_PC, MADR_ALU} mem_addr_sel_t;
   // OLDPC is the address of the instruction being executed; PC has already advanced.
   typedef enum logic [1:0] {SRC1_PC, SRC1_OLDPC, SRC1_RS1, SRC1_ZERO} alu_src1_sel_t;
   typedef enum logic [1:0] {SRC2_4, SRC2_RS2, SRC2_IMM} alu_src2_sel_t;
   typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4, RES_MULDIV} result_sel_t;

   typedef struct packed {
      logic          pc_en;
      logic          inst_en;
      logic          reg_wren;
      logic          mem_wren;
      logic          mem_rden;
      logic          muldiv_start;
      logic          illegal;
      alu_ops_t      aluop;
      mem_addr_sel_t mem_addr_sel;
      alu_src1_sel_t alu_src1_sel;
      alu_src2_sel_t alu_src2_sel;
      result_sel_t   result_sel;
   } ctl_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] FUNCT7_M  = 7'b0000001;
endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus funct fields onto a concrete ALU operation.
module alu_decoder
   import control_pkg::*;
(
   input  alu_ops_t   aluop_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   output alu_ctrl_t  alu_ctrl_o
);
   always_comb begin
      alu_ctrl_o = ALU_ADD;
      case (aluop_i)
         ALUOP_ADD: alu_ctrl_o = ALU_ADD;
         ALUOP_SUB: alu_ctrl_o = ALU_SUB;
         default: begin
            case (funct3_i)
               // Only R-type uses bit 30 to select SUB; ADDI has no such form.
               3'b000:  alu_ctrl_o = (aluop_i == ALUOP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_ctrl_o = ALU_SLL;
               3'b010:  alu_ctrl_o = ALU_SLT;
               3'b011:  alu_ctrl_o = ALU_SLTU;
               3'b100:  alu_ctrl_o = ALU_XOR;
               3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
               3'b110:  alu_ctrl_o = ALU_OR;
               default: alu_ctrl_o = ALU_AND;
            endcase
         end
      endcase
   end
endmodule

// File: rtl/imm_decoder.sv
// Selects the immediate format from the opcode.
module imm_decoder
   import control_pkg::*;
(
   input  logic [6:0] opcode_i,
   output imm_ctrl_t  imm_ctrl_o
);
   always_comb begin
      imm_ctrl_o = IMM_I;
      case (opcode_i)
         OP_STORE:         imm_ctrl_o = IMM_S;
         OP_BRANCH:        imm_ctrl_o = IMM_B;
         OP_LUI, OP_AUIPC: imm_ctrl_o = IMM_U;
         OP_JAL:           imm_ctrl_o = IMM_J;
         default:          imm_ctrl_o = IMM_I;
      endcase
   end
endmodule

// File: rtl/multicycle_control_branch_cond.sv
// B-type condition evaluation from ALU compare flags; flags the two undefined funct3 codes.
module branch_cond (
   input  logic [2:0] funct3_i,
   input  logic       alu_zero_i,
   input  logic       alu_lt_i,
   input  logic       alu_ltu_i,
   output logic       taken_o,
   output logic       bad_funct3_o
);
   always_comb begin
      taken_o      = 1'b0;
      bad_funct3_o = 1'b0;
      case (funct3_i)
         3'b000:  taken_o = alu_zero_i;
         3'b001:  taken_o = !alu_zero_i;
         3'b100:  taken_o = alu_lt_i;
         3'b101:  taken_o = !alu_lt_i;
         3'b110:  taken_o = alu_ltu_i;
         3'b111:  taken_o = !alu_ltu_i;
         default: bad_funct3_o = 1'b1;
      endcase
   end
endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I(M) control FSM: sequences fetch/decode/execute/writeback and counts retired instructions.
module multicycle_control
   import control_pkg::*;
#(
   parameter bit ENABLE_M        = 1'b1,
   parameter bit TRAP_ON_ILLEGAL = 1'b1,
   parameter int CNT_W           = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      inst,
   input  logic             alu_zero,
   input  logic             alu_lt,
   input  logic             alu_ltu,
   input  logic             mem_ready,
   input  logic             muldiv_done,
   output logic             pc_en,
   output logic             inst_en,
   output logic             reg_wren,
   output logic             mem_wren,
   output logic             mem_rden,
   output imm_ctrl_t        imm_ctrl,
   output alu_ctrl_t        alu_ctrl,
   output mem_addr_sel_t    mem_addr_sel,
   output alu_src1_sel_t    alu_src1_sel,
   output alu_src2_sel_t    alu_src2_sel,
   output result_sel_t      result_sel,
   output logic             muldiv_start,
   output logic             illegal,
   output state_t           state,
   output logic [CNT_W-1:0] instret
);
   state_t           state_q, state_d, illegal_dst;
   logic             mul_busy_q;
   logic [CNT_W-1:0] instret_q;
   ctl_t             ctl_c, ctl;
   imm_ctrl_t        imm_dec;
   logic [6:0]       opcode, funct7;
   logic [2:0]       funct3;
   logic             taken, bad_funct3, is_m, unused_inst;

   assign opcode      = inst[6:0];
   assign funct3      = inst[14:12];
   assign funct7      = inst[31:25];
   assign is_m        = (funct7 == FUNCT7_M);
   assign illegal_dst = TRAP_ON_ILLEGAL ? TRAP : FETCH;
   assign unused_inst = ^{inst[24:15], inst[11:7]};

   branch_cond u_branch_cond (
      .funct3_i(funct3), .alu_zero_i(alu_zero), .alu_lt_i(alu_lt), .alu_ltu_i(alu_ltu),
      .taken_o(taken), .bad_funct3_o(bad_funct3)
   );
   alu_decoder u_alu_decoder (
      .aluop_i(ctl.aluop), .funct3_i(funct3), .funct7b5_i(funct7[5]), .alu_ctrl_o(alu_ctrl)
   );
   imm_decoder u_imm_decoder (.opcode_i(opcode), .imm_ctrl_o(imm_dec));

   always_comb begin
      state_d = state_q;
      ctl_c   = ctl_t'('0);
      unique case (state_q)
         FETCH: begin
            ctl_c.mem_rden = 1'b1;
            if (mem_ready) begin
               ctl_c.inst_en = 1'b1;
               ctl_c.pc_en   = 1'b1;
               state_d       = DECODE;
            end
         end
         DECODE: begin
            // Branch target (old PC + imm) is precomputed here for BRANCH.
            ctl_c.alu_src1_sel = SRC1_OLDPC;
            ctl_c.alu_src2_sel = SRC2_IMM;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_R:      state_d = !is_m ? EXECR : (ENABLE_M ? MULDIV : illegal_dst);
               OP_IMM:    state_d = EXECI;
               OP_BRANCH: state_d = bad_funct3 ? illegal_dst : BRANCH;
               OP_JAL:    state_d = JAL;
               OP_JALR:   state_d = JALR;
               OP_LUI:    state_d = LUI;
               OP_AUIPC:  state_d = AUIPC;
               default:   state_d = illegal_dst;
            endcase
         end
         MEMADR: begin
            ctl_c.alu_src1_sel = SRC1_RS1;
            ctl_c.alu_src2_sel = SRC2_IMM;
            state_d = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            ctl_c.mem_rden     = 1'b1;
            ctl_c.mem_addr_sel = MADR_ALU;
            if (mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            ctl_c.reg_wren   = 1'b1;
            ctl_c.result_sel = RES_MEM;
            state_d          = FETCH;
         end
         MEMWRITE: begin
            ctl_c.mem_addr_sel = MADR_ALU;
            if (mem_ready) begin
               ctl_c.mem_wren = 1'b1;
               state_d        = FETCH;
            end
         end
         EXECR: begin
            ctl_c.alu_src1_sel = SRC1_RS1;
            ctl_c.alu_src2_sel = SRC2_RS2;
            ctl_c.aluop        = ALUOP_R;
            state_d            = ALUWB;
         end
         EXECI: begin
            ctl_c.alu_src1_sel = SRC1_RS1;
            ctl_c.alu_src2_sel = SRC2_IMM;
            ctl_c.aluop        = ALUOP_I;
            state_d            = ALUWB;
         end
         ALUWB: begin
            ctl_c.reg_wren = 1'b1;
            if (opcode == OP_JAL || opcode == OP_JALR) ctl_c.result_sel = RES_PC4;
            else if (opcode == OP_R && is_m)          ctl_c.result_sel = RES_MULDIV;
            state_d = FETCH;
         end
         BRANCH: begin
            ctl_c.alu_src1_sel = SRC1_RS1;
            ctl_c.alu_src2_sel = SRC2_RS2;
            ctl_c.aluop        = ALUOP_SUB;
            ctl_c.pc_en        = taken;
            state_d            = FETCH;
         end
         JAL, JALR, LUI, AUIPC: begin
            ctl_c.alu_src1_sel = (state_q == JALR) ? SRC1_RS1 :
                                 (state_q == LUI)  ? SRC1_ZERO : SRC1_OLDPC;
            ctl_c.alu_src2_sel = SRC2_IMM;
            ctl_c.pc_en        = (state_q == JAL) || (state_q == JALR);
            state_d            = ALUWB;
         end
         MULDIV: begin
            // done is only honoured once the unit has seen start.
            ctl_c.muldiv_start = !mul_busy_q;
            if (mul_busy_q && muldiv_done) state_d = ALUWB;
         end
         TRAP: ctl_c.illegal = 1'b1;
      endcase
   end

   // Reset forces every control quiet so nothing half-issued completes.
   assign ctl = reset ? ctl_c : ctl_t'('0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= FETCH;
         mul_busy_q <= 1'b0;
         instret_q  <= '0;
      end else begin
         state_q    <= state_d;
         mul_busy_q <= (state_q == MULDIV);
         if (state_d == FETCH && state_q != FETCH && state_q != TRAP)
            instret_q <= instret_q + CNT_W'(1);
      end
   end

   assign pc_en        = ctl.pc_en;
   assign inst_en      = ctl.inst_en;
   assign reg_wren     = ctl.reg_wren;
   assign mem_wren     = ctl.mem_wren;
   assign mem_rden     = ctl.mem_rden;
   assign muldiv_start = ctl.muldiv_start;
   assign illegal      = ctl.illegal;
   assign mem_addr_sel = ctl.mem_addr_sel;
   assign alu_src1_sel = ctl.alu_src1_sel;
   assign alu_src2_sel = ctl.alu_src2_sel;
   assign result_sel   = ctl.result_sel;
   assign imm_ctrl     = reset ? imm_dec : IMM_I;
   assign state        = state_q;
   assign instret      = instret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: default build, ENABLE_M=0 build, and NOP-illegal CNT_W=4 build.
module tb_multicycle_control;
   import control_pkg::*;

   logic        clk = 1'b0;
   logic        reset, mem_ready, alu_zero, alu_lt, alu_ltu, muldiv_done;
   logic [31:0] inst;
   int          total = 0;
   int          bad = 0;
   int          n, nrd, nwr, nreg, nst, nmd;

   always #5 clk = ~clk;

   logic a_pc_en, a_inst_en, a_reg_wren, a_mem_wren, a_mem_rden, a_muldiv_start, a_illegal;
   imm_ctrl_t a_imm_ctrl;  alu_ctrl_t a_alu_ctrl;  mem_addr_sel_t a_mem_addr_sel;
   alu_src1_sel_t a_src1;  alu_src2_sel_t a_src2;  result_sel_t a_res;
   state_t a_state;        logic [31:0] a_instret;

   logic b_pc_en, b_inst_en, b_reg_wren, b_mem_wren, b_mem_rden, b_muldiv_start, b_illegal;
   imm_ctrl_t b_imm_ctrl;  alu_ctrl_t b_alu_ctrl;  mem_addr_sel_t b_mem_addr_sel;
   alu_src1_sel_t b_src1;  alu_src2_sel_t b_src2;  result_sel_t b_res;
   state_t b_state;        logic [31:0] b_instret;

   logic c_pc_en, c_inst_en, c_reg_wren, c_mem_wren, c_mem_rden, c_muldiv_start, c_illegal;
   imm_ctrl_t c_imm_ctrl;  alu_ctrl_t c_alu_ctrl;  mem_addr_sel_t c_mem_addr_sel;
   alu_src1_sel_t c_src1;  alu_src2_sel_t c_src2;  result_sel_t c_res;
   state_t c_state;        logic [3:0] c_instret;

   logic unused_b, unused_c;
   assign unused_b = ^{b_pc_en, b_inst_en, b_reg_wren, b_mem_wren, b_mem_rden, b_muldiv_start,
                       b_illegal, b_imm_ctrl, b_alu_ctrl, b_mem_addr_sel, b_src1, b_src2, b_res,
                       b_state, b_instret};
   assign unused_c = ^{c_pc_en, c_inst_en, c_reg_wren, c_mem_wren, c_mem_rden, c_muldiv_start,
                       c_illegal, c_imm_ctrl, c_alu_ctrl, c_mem_addr_sel, c_src1, c_src2, c_res,
                       c_state, c_instret};

   multicycle_control u_a (
      .clk(clk), .reset(reset), .inst(inst), .alu_zero(alu_zero), .alu_lt(alu_lt),
      .alu_ltu(alu_ltu), .mem_ready(mem_ready), .muldiv_done(muldiv_done),
      .pc_en(a_pc_en), .inst_en(a_inst_en), .reg_wren(a_reg_wren), .mem_wren(a_mem_wren),
      .mem_rden(a_mem_rden), .imm_ctrl(a_imm_ctrl), .alu_ctrl(a_alu_ctrl),
      .mem_addr_sel(a_mem_addr_sel), .alu_src1_sel(a_src1), .alu_src2_sel(a_src2),
      .result_sel(a_res), .muldiv_start(a_muldiv_start), .illegal(a_illegal),
      .state(a_state), .instret(a_instret));

   multicycle_control #(.ENABLE_M(1'b0)) u_b (
      .clk(clk), .reset(reset), .inst(inst), .alu_zero(alu_zero), .alu_lt(alu_lt),
      .alu_ltu(alu_ltu), .mem_ready(mem_ready), .muldiv_done(muldiv_done),
      .pc_en(b_pc_en), .inst_en(b_inst_en), .reg_wren(b_reg_wren), .mem_wren(b_mem_wren),
      .mem_rden(b_mem_rden), .imm_ctrl(b_imm_ctrl), .alu_ctrl(b_alu_ctrl),
      .mem_addr_sel(b_mem_addr_sel), .alu_src1_sel(b_src1), .alu_src2_sel(b_src2),
      .result_sel(b_res), .muldiv_start(b_muldiv_start), .illegal(b_illegal),
      .state(b_state), .instret(b_instret));

   multicycle_control #(.TRAP_ON_ILLEGAL(1'b0), .CNT_W(4)) u_c (
      .clk(clk), .reset(reset), .inst(inst), .alu_zero(alu_zero), .alu_lt(alu_lt),
      .alu_ltu(alu_ltu), .mem_ready(mem_ready), .muldiv_done(muldiv_done),
      .pc_en(c_pc_en), .inst_en(c_inst_en), .reg_wren(c_reg_wren), .mem_wren(c_mem_wren),
      .mem_rden(c_mem_rden), .imm_ctrl(c_imm_ctrl), .alu_ctrl(c_alu_ctrl),
      .mem_addr_sel(c_mem_addr_sel), .alu_src1_sel(c_src1), .alu_src2_sel(c_src2),
      .result_sel(c_res), .muldiv_start(c_muldiv_start), .illegal(c_illegal),
      .state(c_state), .instret(c_instret));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      cyc();
      reset = 1'b1;
   endtask

   logic [31:0] br_inst [6] = '{32'h0020_8463, 32'h0020_9463, 32'h0020_C463,
                                32'h0020_D463, 32'h0020_E463, 32'h0020_F463};
   logic [2:0]  br_flg  [6] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b000};
   logic [5:0]  br_exp      = 6'b110101;

   initial begin
      reset = 1'b1; inst = 32'h0020_81B3; mem_ready = 1'b0;
      alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; muldiv_done = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("rst_state", 32'(a_state), 32'(FETCH));
      chk("rst_en", {25'b0, a_pc_en, a_inst_en, a_reg_wren, a_mem_wren, a_mem_rden,
                     a_muldiv_start, a_illegal}, 32'd0);
      chk("rst_sel", {25'b0, a_mem_addr_sel, a_src1, a_src2, a_res}, 32'd0);
      chk("rst_instret", a_instret, 32'd0);
      cyc();
      chk("rst_hold", 32'(a_state), 32'(FETCH));

      // add x3,x1,x2
      reset = 1'b1; mem_ready = 1'b1;
      #1;
      chk("add_fetch_en", {29'b0, a_pc_en, a_inst_en, a_mem_rden}, 32'd7);
      cyc(); chk("add_decode", 32'(a_state), 32'(DECODE));
      chk("add_dec_pc_en", 32'(a_pc_en), 32'd0);
      cyc(); chk("add_execr", 32'(a_state), 32'(EXECR));
      chk("add_execr_wren", 32'(a_reg_wren), 32'd0);
      chk("add_alu_ctrl", 32'(a_alu_ctrl), 32'(ALU_ADD));
      cyc(); chk("add_aluwb", 32'(a_state), 32'(ALUWB));
      chk("add_wb_wren", 32'(a_reg_wren), 32'd1);
      chk("add_wb_res", 32'(a_res), 32'(RES_ALU));
      chk("add_instret0", a_instret, 32'd0);
      cyc(); chk("add_fetch", 32'(a_state), 32'(FETCH));
      chk("add_instret1", a_instret, 32'd1);
      chk("add_wren_off", 32'(a_reg_wren), 32'd0);

      // lw x5,0(x1) with three stall cycles in MEMREAD
      inst = 32'h0000_A283; n = 0; nrd = 0; nwr = 0; nreg = 0;
      do begin
         mem_ready = !(a_state == MEMREAD && nrd < 3);
         if (a_state == MEMREAD) nrd++;
         #1;
         nwr += int'(a_mem_wren);
         nreg += int'(a_reg_wren);
         n++;
         cyc();
      end while (a_state != FETCH && n < 20);
      mem_ready = 1'b1;
      chk("lw_cycles", 32'(n), 32'd8);
      chk("lw_memread_cycles", 32'(nrd), 32'd4);
      chk("lw_mem_wren", 32'(nwr), 32'd0);
      chk("lw_reg_wren", 32'(nreg), 32'd1);
      chk("lw_instret", a_instret, 32'd2);

      // all six branch conditions
      for (int i = 0; i < 6; i++) begin
         inst = br_inst[i];
         {alu_zero, alu_lt, alu_ltu} = br_flg[i];
         cyc(); cyc();
         chk($sformatf("br%0d_state", i), 32'(a_state), 32'(BRANCH));
         chk($sformatf("br%0d_pc_en", i), 32'(a_pc_en), 32'(br_exp[i]));
         chk($sformatf("br%0d_imm", i), 32'(a_imm_ctrl), 32'(IMM_B));
         cyc();
      end
      chk("br_instret", a_instret, 32'd8);

      // branch funct3=010 is illegal
      inst = 32'h0020_A463; {alu_zero, alu_lt, alu_ltu} = 3'b000;
      cyc(); cyc();
      chk("bad_f3_trap", 32'(a_state), 32'(TRAP));
      chk("bad_f3_illegal", 32'(a_illegal), 32'd1);
      chk("bad_f3_nop_c", 32'(c_state), 32'(FETCH));
      cyc();
      chk("trap_stays", 32'(a_state), 32'(TRAP));
      chk("trap_instret", a_instret, 32'd8);
      chk("trap_no_rden", 32'(a_mem_rden), 32'd0);
      reset = 1'b0;
      #1;
      chk("trap_reset_state", 32'(a_state), 32'(FETCH));
      chk("trap_reset_illegal", 32'(a_illegal), 32'd0);
      chk("trap_reset_instret", a_instret, 32'd0);
      cyc();
      reset = 1'b1;

      // mul x3,x1,x2; done pulse in the start cycle must be ignored
      inst = 32'h0220_81B3;
      cyc(); cyc();
      chk("mul_state", 32'(a_state), 32'(MULDIV));
      chk("mul_nom_trap", 32'(b_state), 32'(TRAP));
      chk("mul_nom_illegal", 32'(b_illegal), 32'd1);
      nst = 0; nmd = 0;
      for (int i = 0; i < 6; i++) begin
         muldiv_done = (i == 0 || i == 5);
         #1;
         nst += int'(a_muldiv_start);
         nmd += int'(a_state == MULDIV);
         cyc();
      end
      muldiv_done = 1'b0;
      chk("mul_start_pulses", 32'(nst), 32'd1);
      chk("mul_wait_cycles", 32'(nmd), 32'd6);
      chk("mul_aluwb", 32'(a_state), 32'(ALUWB));
      chk("mul_res_sel", 32'(a_res), 32'(RES_MULDIV));
      chk("mul_wb_wren", 32'(a_reg_wren), 32'd1);
      cyc();
      chk("mul_instret", a_instret, 32'd1);
      chk("mul_nom_instret", b_instret, 32'd0);

      // opcode 7F as a NOP on the non-trapping build, then CNT_W=4 wrap
      inst = 32'h0000_007F;
      do_reset();
      cyc();
      chk("nop_decode", 32'(c_state), 32'(DECODE));
      chk("nop_no_writes", {30'b0, c_reg_wren, c_mem_wren}, 32'd0);
      cyc();
      chk("nop_fetch", 32'(c_state), 32'(FETCH));
      chk("nop_instret", 32'(c_instret), 32'd1);
      chk("nop_trap_a", 32'(a_state), 32'(TRAP));
      for (int i = 0; i < 14; i++) begin
         cyc(); cyc();
      end
      chk("wrap_15", 32'(c_instret), 32'd15);
      cyc(); cyc();
      chk("wrap_0", 32'(c_instret), 32'd0);

      // sw x2,0(x1) with mem_ready high: 4 cycles, exactly one write
      inst = 32'h0020_A023;
      do_reset();
      n = 0; nwr = 0; nreg = 0;
      do begin
         #1;
         nwr += int'(a_mem_wren);
         nreg += int'(a_reg_wren);
         n++;
         cyc();
      end while (a_state != FETCH && n < 20);
      chk("sw_cycles", 32'(n), 32'd4);
      chk("sw_mem_wren", 32'(nwr), 32'd1);
      chk("sw_reg_wren", 32'(nreg), 32'd0);
      chk("sw_instret", a_instret, 32'd1);

      // reset during a MEMWRITE stall
      cyc(); cyc();
      mem_ready = 1'b0;
      cyc();
      chk("stall_state", 32'(a_state), 32'(MEMWRITE));
      chk("stall_wren", 32'(a_mem_wren), 32'd0);
      cyc();
      reset = 1'b0;
      #1;
      chk("midrst_state", 32'(a_state), 32'(FETCH));
      chk("midrst_wren", 32'(a_mem_wren), 32'd0);
      chk("midrst_instret", a_instret, 32'd0);
      mem_ready = 1'b1;
      #1;
      chk("midrst_ready_wren", 32'(a_mem_wren), 32'd0);
      chk("midrst_ready_rden", 32'(a_mem_rden), 32'd0);
      cyc();
      reset = 1'b1;
      #1;
      chk("post_rst_state", 32'(a_state), 32'(FETCH));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
